// File: rtl/pid_pwm_driver.sv
// Turns the pid's signed fixed-point output into sign/magnitude PWM for an H-bridge, with dead time on reversal.
// Outputs are decoded combinationally from registered state (zero latency); there is no backpressure, and u is sampled only at period boundaries.
module pid_pwm_driver #(
  parameter int D_WIDTH   = 32,
  parameter int FRAC_BITS = 15,
  parameter int PERIOD    = 1000,
  parameter int CNT_WIDTH = 10,
  parameter int DEADTIME  = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [D_WIDTH-1:0] u,
  output logic               pwm_out,
  output logic               dir_out,
  output logic               sample_strobe,
  output logic               saturated
);

  localparam int MW = D_WIDTH + 1;
  localparam int PW = FRAC_BITS + 1 + CNT_WIDTH;
  localparam logic [MW-1:0]      FULL_EXT = MW'(1) << FRAC_BITS;
  localparam logic [FRAC_BITS:0] FULL     = {1'b1, {FRAC_BITS{1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [CNT_WIDTH-1:0] dt_cnt, dt_nxt;
  logic [CNT_WIDTH-1:0] duty_reg;
  logic                 dir_reg, sat_reg;
  logic                 load;

  // One extra bit so the most negative u still has a representable magnitude.
  logic [MW-1:0]        u_ext, mag;
  logic                 mag_sat;
  logic [FRAC_BITS:0]   mag_clip;
  logic [PW-1:0]        prod;
  logic [CNT_WIDTH-1:0] duty_new;
  logic                 dir_new;
  logic                 unused_prod_bits;

  assign u_ext    = {u[D_WIDTH-1], u};
  assign mag      = u[D_WIDTH-1] ? (~u_ext + MW'(1)) : u_ext;
  assign mag_sat  = mag > FULL_EXT;
  assign mag_clip = mag_sat ? FULL : mag[FRAC_BITS:0];
  assign prod     = PW'(mag_clip) * PW'(PERIOD);
  assign duty_new = prod[FRAC_BITS +: CNT_WIDTH];
  assign dir_new  = u[D_WIDTH-1];
  assign unused_prod_bits = ^{prod[PW-1], prod[FRAC_BITS-1:0]};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dt_nxt    = dt_cnt;
    load      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (enable) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          dt_nxt    = '0;
        end else begin
          if (dt_cnt != '0) dt_nxt = dt_cnt - 1'b1;
          if (cnt == CNT_WIDTH'(PERIOD - 1)) begin
            cnt_nxt = '0;
            load    = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A reversal at a load restarts the dead-time window for the new period.
    if (load && (dir_new != dir_reg)) dt_nxt = CNT_WIDTH'(DEADTIME);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      dt_cnt   <= '0;
      duty_reg <= '0;
      dir_reg  <= 1'b0;
      sat_reg  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      dt_cnt <= dt_nxt;
      if (load) begin
        duty_reg <= duty_new;
        dir_reg  <= dir_new;
        sat_reg  <= mag_sat;
      end
    end
  end

  assign pwm_out       = (state == RUN) && (cnt < duty_reg) && (dt_cnt == '0);
  assign sample_strobe = (state == RUN) && (cnt == '0);
  assign dir_out       = dir_reg;
  assign saturated     = sat_reg;

endmodule
